// File: rtl/fwd_tracker.sv
// Forwarding/hazard tracker: follows destination registers through DEPTH post-decode stages.
// Latency: hazard_stall same cycle from ID inputs; fwd_sel combinational from registered EX/pipe state.
// Backpressure: pipe_hold freezes all state; hazard_stall asks upstream to hold PC and IF/ID.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   pipe_hold             global freeze, nothing advances
//   id_flush              kill the ID instruction (bubble into EX, no stall)
//   id_valid/id_dst_we/id_dst/id_is_load   ID instruction producer info
//   id_src/id_src_used    ID source registers (operand i at [i*A_W +: A_W]) and use flags
//   hazard_stall          load-use stall request for the ID instruction
//   fwd_sel               per-operand forwarding select for EX (0 = regfile, k-1 = stage P[k])
//   stall_cnt             saturating count of effective stall cycles
module fwd_tracker #(
  parameter int A_W     = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_hold,
  input  logic                     id_flush,
  input  logic                     id_valid,
  input  logic                     id_dst_we,
  input  logic [A_W-1:0]           id_dst,
  input  logic                     id_is_load,
  input  logic [NUM_SRC*A_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  output logic                     hazard_stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Index k here is stage P[k+1]: index 0 is EX, index DEPTH-1 is WB.
  logic [DEPTH-1:0]       p_vld_q, p_vld_d;
  logic [DEPTH-1:0]       p_ld_q, p_ld_d;
  logic [A_W-1:0]         p_dst_q [DEPTH];
  logic [A_W-1:0]         p_dst_d [DEPTH];
  logic [NUM_SRC*A_W-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]     ex_used_q, ex_used_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [DEPTH-1:0]       live;

  // r0 is filtered on entry, but the dst check keeps "live" self-contained.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      live[k] = p_vld_q[k] && (p_dst_q[k] != '0);
    end
  end

  // Load-use: only a load sitting in EX can create a hazard; flush overrides it.
  always_comb begin
    hazard_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_valid && id_src_used[i] && live[0] && p_ld_q[0] &&
          (id_src[i*A_W +: A_W] == p_dst_q[0])) begin
        hazard_stall = 1'b1;
      end
    end
    if (id_flush) begin
      hazard_stall = 1'b0;
    end
  end

  // Scan oldest to youngest so the nearest matching producer overwrites the rest.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (ex_used_q[i] && live[k] && (p_dst_q[k] == ex_src_q[i*A_W +: A_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    p_vld_d     = p_vld_q;
    p_ld_d      = p_ld_q;
    p_dst_d     = p_dst_q;
    ex_src_d    = ex_src_q;
    ex_used_d   = ex_used_q;
    stall_cnt_d = stall_cnt_q;
    if (!pipe_hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        p_vld_d[k] = p_vld_q[k-1];
        p_ld_d[k]  = p_ld_q[k-1];
        p_dst_d[k] = p_dst_q[k-1];
      end
      if (id_flush || hazard_stall) begin
        p_vld_d[0] = 1'b0;
        p_ld_d[0]  = 1'b0;
        p_dst_d[0] = '0;
        ex_used_d  = '0;
      end else begin
        p_vld_d[0] = id_valid && id_dst_we && (id_dst != '0);
        p_ld_d[0]  = id_is_load;
        p_dst_d[0] = id_dst;
        ex_src_d   = id_src;
        ex_used_d  = id_src_used & {NUM_SRC{id_valid}};
      end
      if (hazard_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld_q     <= '0;
      p_ld_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        p_dst_q[k] <= '0;
      end
      ex_src_q    <= '0;
      ex_used_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      p_vld_q     <= p_vld_d;
      p_ld_q      <= p_ld_d;
      p_dst_q     <= p_dst_d;
      ex_src_q    <= ex_src_d;
      ex_used_q   <= ex_used_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_tracker.sv
// Directed bench for fwd_tracker (DEPTH=3, CNT_W reduced to 8 so saturation is reachable quickly).
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: exercises pipe_hold freeze, load-use stall and flush priority.
module tb_fwd_tracker;
  localparam int A_W = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH = 3;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     pipe_hold, id_flush, id_valid, id_dst_we, id_is_load;
  logic [A_W-1:0]           id_dst;
  logic [NUM_SRC*A_W-1:0]   id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic                     hazard_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [CNT_W-1:0]         stall_cnt;

  int n_assert = 0;
  int n_fail = 0;

  fwd_tracker #(.A_W(A_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .id_flush(id_flush),
    .id_valid(id_valid), .id_dst_we(id_dst_we), .id_dst(id_dst), .id_is_load(id_is_load),
    .id_src(id_src), .id_src_used(id_src_used), .hazard_stall(hazard_stall),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present an ID instruction and let the combinational outputs settle.
  task automatic id_in(input logic v, input logic we, input int dst, input logic ld,
                       input int s0, input int s1, input logic [1:0] used);
    id_valid    = v;
    id_dst_we   = we;
    id_dst      = A_W'(dst);
    id_is_load  = ld;
    id_src      = {A_W'(s1), A_W'(s0)};
    id_src_used = used;
    #1;
  endtask

  task automatic nop();
    id_in(1'b0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; pipe_hold = 1'b0; id_flush = 1'b0;
    nop();
    #3;
    chk("rst_hazard", int'(hazard_stall), 0);
    chk("rst_fwd", int'(fwd_sel), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_fwd", int'(fwd_sel), 0);

    // add r3 -> consumer of r3 next: op0 from MEM
    id_in(1, 1, 3, 0, 1, 2, 2'b11); tick();
    id_in(1, 0, 0, 0, 3, 7, 2'b11); tick();
    chk("dist1_fwd", int'(fwd_sel), 4'b0001);
    drain();

    // add r3, independent, consumer op1=r3: from WB
    id_in(1, 1, 3, 0, 1, 2, 2'b11); tick();
    id_in(1, 1, 8, 0, 1, 2, 2'b11); tick();
    id_in(1, 0, 0, 0, 9, 3, 2'b11); tick();
    chk("dist2_fwd", int'(fwd_sel), 4'b1000);
    drain();

    // two independents between: producer retired, regfile
    id_in(1, 1, 3, 0, 1, 2, 2'b11); tick();
    id_in(1, 1, 8, 0, 1, 2, 2'b11); tick();
    id_in(1, 1, 9, 0, 1, 2, 2'b11); tick();
    id_in(1, 0, 0, 0, 3, 3, 2'b11); tick();
    chk("dist3_fwd", int'(fwd_sel), 0);
    drain();

    // r5 written twice in a row: nearest (MEM) wins for both operands
    id_in(1, 1, 5, 0, 1, 2, 2'b11); tick();
    id_in(1, 1, 5, 0, 1, 2, 2'b11); tick();
    id_in(1, 0, 0, 0, 5, 5, 2'b11); tick();
    chk("nearest_fwd", int'(fwd_sel), 4'b0101);
    drain();

    // lw r4; add r6,r4,r2
    id_in(1, 1, 4, 1, 1, 0, 2'b01); tick();
    id_in(1, 1, 6, 0, 4, 2, 2'b11);
    chk("lu_hazard", int'(hazard_stall), 1);
    tick();
    chk("lu_cnt", int'(stall_cnt), 1);
    chk("lu_hazard_once", int'(hazard_stall), 0);
    chk("lu_bubble_fwd", int'(fwd_sel), 0);
    tick();
    chk("lu_fwd", int'(fwd_sel), 4'b0010);
    chk("lu_cnt_after", int'(stall_cnt), 1);
    drain();

    // r0 producer is never forwarded; a load to r0 never stalls
    id_in(1, 1, 0, 1, 1, 2, 2'b11); tick();
    id_in(1, 0, 0, 0, 0, 0, 2'b11);
    chk("r0_no_stall", int'(hazard_stall), 0);
    tick();
    chk("r0_fwd", int'(fwd_sel), 0);
    drain();

    // load then consumer with no used operands, then an invalid ID
    id_in(1, 1, 4, 1, 1, 0, 2'b01); tick();
    id_in(1, 0, 0, 0, 4, 4, 2'b00);
    chk("unused_no_stall", int'(hazard_stall), 0);
    id_in(0, 0, 0, 0, 4, 4, 2'b11);
    chk("invalid_no_stall", int'(hazard_stall), 0);
    drain();

    // pipe_hold for 3 edges while a stall is pending
    id_in(1, 1, 4, 1, 1, 0, 2'b01); tick();
    id_in(1, 1, 6, 0, 4, 2, 2'b11);
    pipe_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_hazard", int'(hazard_stall), 1);
      chk("hold_cnt", int'(stall_cnt), 1);
    end
    pipe_hold = 1'b0;
    tick();
    chk("hold_release_cnt", int'(stall_cnt), 2);
    chk("hold_release_hazard", int'(hazard_stall), 0);
    drain();

    // flush beats load-use; the flushed load must not enter EX
    id_in(1, 1, 4, 1, 1, 0, 2'b01); tick();
    id_flush = 1'b1;
    id_in(1, 1, 4, 1, 4, 0, 2'b01);
    chk("flush_hazard", int'(hazard_stall), 0);
    tick();
    id_flush = 1'b0;
    chk("flush_cnt", int'(stall_cnt), 2);
    id_in(1, 0, 0, 0, 4, 4, 2'b11);
    chk("flush_bubble", int'(hazard_stall), 0);
    drain();

    // mid-stream async reset
    id_in(1, 1, 3, 0, 1, 2, 2'b11); tick();
    id_in(1, 1, 4, 1, 3, 0, 2'b01); tick();
    id_in(1, 0, 0, 0, 4, 0, 2'b01);
    chk("pre_rst_fwd", int'(fwd_sel), 4'b0001);
    chk("pre_rst_hazard", int'(hazard_stall), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_fwd", int'(fwd_sel), 0);
    chk("mid_rst_hazard", int'(hazard_stall), 0);
    chk("mid_rst_cnt", int'(stall_cnt), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rst_hazard", int'(hazard_stall), 0);

    // self-dependent load repeated: one stall every two cycles, counter saturates
    id_in(1, 1, 4, 1, 4, 0, 2'b01);
    repeat (510) tick();
    chk("sat_cnt", int'(stall_cnt), 255);
    tick();
    chk("sat_hazard", int'(hazard_stall), 1);
    tick();
    chk("sat_hold", int'(stall_cnt), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
